// File: rtl/serial_tx_pkg.sv
// Shared FSM state encoding and frame constants for serial_frame_tx.
// Frame length follows SERIAL_TX_PARITY_EN: 10 bits, or 11 with even parity.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2
    } state_e;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Bit 0 goes out first, so the frame is packed LSB-first.
    function automatic frame_t build_frame(input logic [7:0] data);
        frame_t f;
`ifdef SERIAL_TX_PARITY_EN
        f = {STOP_BIT, ^data, data, START_BIT};
`else
        f = {STOP_BIT, data, START_BIT};
`endif
        return f;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Byte handshake and serial link signals of serial_frame_tx.
// master = byte producer / link observer, slave = the framer.
interface serial_frame_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    data_i;
    logic          valid_i;
    logic          ready_o;
    logic          sclk_o;
    logic          sdo_o;
    logic          busy_o;
    logic [LW-1:0] level_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, sclk_o, sdo_o, busy_o, level_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, sclk_o, sdo_o, busy_o, level_o
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous byte FIFO with registered full/level; a push while full is refused
// even if a pop happens on the same edge.
module serial_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && (level_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d   = (level_d == LW'(DEPTH));
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Byte-to-serial framer: FIFO-buffered bytes leave as start/data(LSB first)/stop frames
// on SCLK/SDO. Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_frame_tx #(
    parameter int CLKDIV     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    serial_frame_tx_if.slave  bus
);
    import serial_tx_pkg::*;

    localparam int         LW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] DIV_RELOAD = 8'(CLKDIV - 1);
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

    state_e        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    frame_t        shift_q, shift_d;
    logic          sclk_q, sclk_d;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;

    serial_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.valid_i),
        .pop_i   (pop),
        .din_i   (bus.data_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                div_d  = DIV_RELOAD;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = build_frame(fifo_dout);
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == '0) begin
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            ST_PULSE: begin
                if (div_q == '0) begin
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b0;
                    // Shifting in ones leaves sdo at the idle level once the frame drains.
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    state_d = ST_SETUP;
                    if (bit_q != LAST_BIT) begin
                        bit_d = bit_q + 4'd1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = build_frame(fifo_dout);
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_RELOAD;
            bit_q   <= '0;
            shift_q <= '1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
        end
    end

    assign bus.sclk_o  = sclk_q;
    assign bus.sdo_o   = shift_q[0];
    assign bus.ready_o = !fifo_full;
    assign bus.level_o = fifo_level;
    assign bus.busy_o  = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: a receiver model decodes SCLK/SDO rises
// and compares them with the bytes the bench pushed.
module tb_serial_frame_tx;

    localparam int CLKDIV  = 4;
    localparam int DEPTH   = 4;
    localparam int BIT_CYC = 2 * CLKDIV;
    localparam int LIMIT   = 3000;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    serial_frame_tx #(.CLKDIV(CLKDIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rise_cyc[$];
    bit   rise_bit[$];
    logic [7:0] exp_q[$];
    int   stable_err = 0;
    int   level_err  = 0;
    int   ready_err  = 0;
    logic prev_sclk  = 1'b0;
    logic prev_sdo   = 1'b1;
    int   full_seen_level = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model plus link invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sclk_o && !prev_sclk) begin
                rise_cyc.push_back(cyc);
                rise_bit.push_back(bus.sdo_o);
            end
            if (bus.sclk_o && prev_sclk && (bus.sdo_o !== prev_sdo)) stable_err <= stable_err + 1;
            if (int'(bus.level_o) > DEPTH) level_err <= level_err + 1;
            if (bus.ready_o !== (int'(bus.level_o) != DEPTH)) ready_err <= ready_err + 1;
            prev_sclk <= bus.sclk_o;
            prev_sdo  <= bus.sdo_o;
        end else begin
            prev_sclk <= 1'b0;
            prev_sdo  <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called on a negedge; returns on the negedge after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int w = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = b;
        while (!bus.ready_o && w < LIMIT) begin
            if (full_seen_level < 0) full_seen_level = int'(bus.level_o);
            @(negedge clk);
            w++;
        end
        chk("send ready", 32'(bus.ready_o), 32'd1);
        exp_q.push_back(b);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        while ((bus.busy_o || bus.level_o != '0) && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " busy fell"}, 32'(bus.busy_o), 32'd0);
        chk({tag, " sdo idle"}, 32'(bus.sdo_o), 32'd1);
    endtask

    // Decode the captured rises into frames and compare against the pushed bytes.
    task automatic check_frames(input string tag, input bit contiguous);
        int nf;
        int bad;
        logic [7:0] d;
        logic [7:0] e;
        nf  = exp_q.size();
        bad = 0;
        chk({tag, " rise count"}, 32'(rise_bit.size()), 32'(nf * FB));
        if (rise_bit.size() == nf * FB) begin
            for (int f = 0; f < nf; f++) begin
                e = exp_q[f];
                for (int k = 0; k < 8; k++) d[k] = rise_bit[f*FB + 1 + k];
                chk({tag, " start bit"}, 32'(rise_bit[f*FB]), 32'd0);
                chk({tag, " data"}, 32'(d), 32'(e));
`ifdef SERIAL_TX_PARITY_EN
                chk({tag, " parity"}, 32'(rise_bit[f*FB + 9]), 32'(^e));
`endif
                chk({tag, " stop bit"}, 32'(rise_bit[f*FB + FB - 1]), 32'd1);
            end
            for (int k = 1; k < rise_cyc.size(); k++) begin
                if ((contiguous || (k % FB) != 0) && (rise_cyc[k] - rise_cyc[k-1] != BIT_CYC)) bad++;
            end
            chk({tag, " rise spacing"}, 32'(bad), 32'd0);
        end
        rise_bit.delete();
        rise_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int t_start;
        int w;
        logic [7:0] burst [6];
        burst = '{8'h31, 8'h41, 8'h2A, 8'h32, 8'h0D, 8'h0A};

        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset sdo", 32'(bus.sdo_o), 32'd1);
        chk("reset sclk", 32'(bus.sclk_o), 32'd0);
        chk("reset ready", 32'(bus.ready_o), 32'd1);
        chk("reset level", 32'(bus.level_o), 32'd0);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle no sclk rises", 32'(rise_bit.size()), 32'd0);
        chk("idle sdo", 32'(bus.sdo_o), 32'd1);
        chk("idle busy", 32'(bus.busy_o), 32'd0);

        // Single byte with latency checks
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h31;
        exp_q.push_back(8'h31);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("push level", 32'(bus.level_o), 32'd1);
        chk("push sdo still idle", 32'(bus.sdo_o), 32'd1);
        @(negedge clk);
        chk("start bit latency", 32'(bus.sdo_o), 32'd0);
        chk("pop level", 32'(bus.level_o), 32'd0);
        t_start = cyc;
        wait_idle("single");
        chk("first rise delay", 32'((rise_cyc.size() > 0) ? rise_cyc[0] - t_start : -1), 32'(CLKDIV));
        check_frames("single 0x31", 1'b1);

        // String burst as fast as ready allows
        full_seen_level = -1;
        foreach (burst[i]) send(burst[i]);
        chk("burst full level", 32'(full_seen_level), 32'(DEPTH));
        wait_idle("burst");
        check_frames("burst", 1'b1);

        // Full FIFO with a push held across the pop edge
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        chk("full level", 32'(bus.level_o), 32'(DEPTH));
        chk("full ready", 32'(bus.ready_o), 32'd0);
        bus.valid_i = 1'b1;
        bus.data_i  = 8'hC3;
        w = 0;
        while (!bus.ready_o && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("push refused at pop edge", 32'(bus.level_o), 32'(DEPTH - 1));
        exp_q.push_back(8'hC3);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("push accepted after pop", 32'(bus.level_o), 32'(DEPTH));
        wait_idle("full");
        check_frames("full push/pop", 1'b1);

        // Randomized bytes with random gaps
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3 * FB * BIT_CYC / 2)) @(negedge clk);
            send(8'($urandom));
        end
        wait_idle("random");
        check_frames("random", 1'b0);

        // Reset mid-frame
        send(8'hA5);
        send(8'h11);
        send(8'h22);
        w = 0;
        while (rise_bit.size() < 5 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("mid-frame sclk high", 32'(bus.sclk_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async reset sdo", 32'(bus.sdo_o), 32'd1);
        chk("async reset sclk", 32'(bus.sclk_o), 32'd0);
        chk("async reset level", 32'(bus.level_o), 32'd0);
        chk("async reset busy", 32'(bus.busy_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rise_bit.delete();
        rise_cyc.delete();
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("post reset no rises", 32'(rise_bit.size()), 32'd0);
        send(8'h55);
        wait_idle("after reset");
        check_frames("after reset 0x55", 1'b1);

        // Three data bits set: parity bit is 1 in the parity build
        send(8'h07);
        wait_idle("0x07");
        check_frames("0x07", 1'b1);

        chk("sdo stable while sclk high", 32'(stable_err), 32'd0);
        chk("level within range", 32'(level_err), 32'd0);
        chk("ready matches level", 32'(ready_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
